instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Consumer side of the program counter interface. Samples PC, reads instruction memory at that address, and buffers instruction/address pairs in a FIFO for decode.
- The program counter free-runs: it increments on every negedge and cannot be stalled directly.
- This block throttles and redirects the counter only through its load port (USER/USER_PC). While USER is high, PC is forced asynchronously to USER_PC.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- RESET_VECTOR, 8'h00, first fetch address after reset.

Ports:
- CLOCK  in  1  system clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- PC  in  8  current program counter value; changes on negedge, stable at posedge.
- USER  out  1  load/hold request to the program counter.
- USER_PC  out  8  address forced onto the program counter while USER=1.
- MEM_REQ  out  1  instruction memory read request.
- MEM_ADDR  out  8  memory read address.
- MEM_RDATA  in  8  instruction word; valid in the same cycle as MEM_READY.
- MEM_READY  in  1  memory accepts the request this cycle.
- INSTR  out  8  instruction at the FIFO head.
- INSTR_PC  out  8  address of the FIFO head instruction.
- INSTR_VALID  out  1  FIFO not empty.
- INSTR_ACCEPT  in  1  decode pops the FIFO head (effective only when INSTR_VALID=1).
- BRANCH_TAKEN  in  1  redirect request, sampled at posedge.
- BRANCH_TARGET  in  8  redirect address.
- FIFO_LEVEL  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- State and registers:
  - States: RUN, HOLD.
  - Registers: state, HOLD_ADDR[7:0], FIFO storage, read/write pointers, count.
- Reset (while RESET=1, asynchronous):
  - state=HOLD, HOLD_ADDR=RESET_VECTOR, FIFO emptied.
  - Outputs: USER=1, USER_PC=RESET_VECTOR, MEM_REQ=0 (forced), INSTR_VALID=0, FIFO_LEVEL=0.
  - Holding USER high also resets PC to RESET_VECTOR.
- Output decode:
  - USER = (state==HOLD); USER_PC = HOLD_ADDR. Both are registered-state outputs, glitch-free.
  - MEM_ADDR = PC in RUN, HOLD_ADDR in HOLD.
  - MEM_REQ = !RESET & (count < DEPTH). A pop in the same cycle does not free a slot for a push.
- Fetch success (MEM_REQ & MEM_READY at posedge, no branch):
  - Push {MEM_ADDR, MEM_RDATA}; state <= RUN.
  - USER drops after the posedge, so PC increments to MEM_ADDR+1 at the following negedge.
  - Throughput: 1 instruction per cycle.
- Fetch failure (MEM_REQ=0 or MEM_READY=0, no branch):
  - In RUN: HOLD_ADDR <= PC; state <= HOLD. USER rises after the posedge, before the negedge, so PC never advances past the unfetched address.
  - In HOLD: unchanged.
- Branch (BRANCH_TAKEN=1 at posedge; priority over fetch and pop):
  - FIFO flushed (count=0); a same-cycle push is discarded.
  - HOLD_ADDR <= BRANCH_TARGET; state <= HOLD.
  - The memory read issued that cycle is dropped (reads have no side effects).
  - The next cycle may fetch BRANCH_TARGET; first fetch of the target is possible 1 cycle after the branch.
- Pop: INSTR_VALID & INSTR_ACCEPT at posedge advances the read pointer. Simultaneous push+pop leaves count unchanged.
- Wrap-around: addresses are 8-bit modulo. FF is followed by 00 with no special handling. FIFO pointers wrap at DEPTH.
- Priority: RESET > BRANCH_TAKEN > push/pop.
- Reset mid-operation: FIFO contents lost, state -> HOLD at RESET_VECTOR regardless of the pending fetch.
- Invariant: INSTR_PC values leave the FIFO in strict program order (+1 each) except across a branch.

Test Plan:
- Reset, then MEM_READY=1, INSTR_ACCEPT=1 -> during reset USER=1, USER_PC=00, MEM_REQ=0. After release, entries 00,01,02,03 appear on consecutive cycles; USER=0 from the second cycle on.
- MEM_READY=0 for 3 cycles when PC=05 -> USER=1, USER_PC=05, PC held at 05 for the whole stall. MEM_READY=1 -> entry (05, MEM_RDATA) pushed, PC reads 06 after the next negedge.
- DEPTH=4, INSTR_ACCEPT=0 from 00 -> entries 00..03 stored, FIFO_LEVEL=4, MEM_REQ=0, USER=1, USER_PC=04. One accept -> next push has INSTR_PC=04.
- BRANCH_TAKEN, BRANCH_TARGET=40 with FIFO_LEVEL=3 -> next cycle INSTR_VALID=0, FIFO_LEVEL=0, USER_PC=40. Next pushed entry has INSTR_PC=40, followed by 41.
- Fetch across FE, FF, 00, 01 -> INSTR_PC sequence FE, FF, 00, 01 with no gaps or duplicates.
- RESET asserted during a HOLD at 22 with 2 buffered entries -> INSTR_VALID=0 immediately. After release, fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: samples the free-running PC, reads instruction memory and buffers
// {address, instruction} pairs for decode, throttling the PC through its USER/USER_PC load port.
module instr_fetch_unit #(
    parameter int         DEPTH        = 4,
    parameter logic [7:0] RESET_VECTOR = 8'h00,
    localparam int        PTR_W        = $clog2(DEPTH),
    localparam int        CNT_W        = PTR_W + 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [7:0]       PC,
    output logic             USER,
    output logic [7:0]       USER_PC,
    output logic             MEM_REQ,
    output logic [7:0]       MEM_ADDR,
    input  logic [7:0]       MEM_RDATA,
    input  logic             MEM_READY,
    output logic [7:0]       INSTR,
    output logic [7:0]       INSTR_PC,
    output logic             INSTR_VALID,
    input  logic             INSTR_ACCEPT,
    input  logic             BRANCH_TAKEN,
    input  logic [7:0]       BRANCH_TARGET,
    output logic [CNT_W-1:0] FIFO_LEVEL
);

    typedef enum logic {RUN, HOLD} state_e;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    state_e             state_q, state_d;
    logic [7:0]         hold_addr_q, hold_addr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        fifo_q [DEPTH];

    logic fetch_ok;
    logic push;
    logic pop;

    assign USER        = (state_q == HOLD);
    assign USER_PC     = hold_addr_q;
    assign MEM_ADDR    = (state_q == RUN) ? PC : hold_addr_q;
    // A pop in the same cycle never frees a slot for a push; only the registered count gates requests.
    assign MEM_REQ     = !RESET && (count_q != FULL);
    assign INSTR_VALID = (count_q != '0);
    assign INSTR       = fifo_q[rd_ptr_q][7:0];
    assign INSTR_PC    = fifo_q[rd_ptr_q][15:8];
    assign FIFO_LEVEL  = count_q;

    assign fetch_ok = MEM_REQ && MEM_READY;
    assign push     = fetch_ok && !BRANCH_TAKEN;
    assign pop      = INSTR_VALID && INSTR_ACCEPT && !BRANCH_TAKEN;

    // NOTE: every signal is given a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        hold_addr_d = hold_addr_q;
        if (BRANCH_TAKEN) begin
            state_d     = HOLD;
            hold_addr_d = BRANCH_TARGET;
        end else if (fetch_ok) begin
            state_d = RUN;
        end else if (state_q == RUN) begin
            // Freeze the PC on the address that was not fetched so it is retried next cycle.
            state_d     = HOLD;
            hold_addr_d = PC;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (BRANCH_TAKEN) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q     <= HOLD;
            hold_addr_q <= RESET_VECTOR;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_addr_q <= hold_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; count_q alone decides which entries are valid.
    always_ff @(posedge CLOCK) begin
        if (push) fifo_q[wr_ptr_q] <= {MEM_ADDR, MEM_RDATA};
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a free-running PC model plus a queue-based
// reference that tracks the next address to fetch and the decode buffer contents.
module tb_instr_fetch_unit;

    localparam int         DEPTH = 4;
    localparam logic [7:0] RV    = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pc;
    logic       user;
    logic [7:0] user_pc;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata = '0;
    logic       mem_ready = 1'b0;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_accept = 1'b0;
    logic       branch_taken = 1'b0;
    logic [7:0] branch_target = '0;
    logic [2:0] fifo_level;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
        .CLOCK        (clk),
        .RESET        (rst),
        .PC           (pc),
        .USER         (user),
        .USER_PC      (user_pc),
        .MEM_REQ      (mem_req),
        .MEM_ADDR     (mem_addr),
        .MEM_RDATA    (mem_rdata),
        .MEM_READY    (mem_ready),
        .INSTR        (instr),
        .INSTR_PC     (instr_pc),
        .INSTR_VALID  (instr_valid),
        .INSTR_ACCEPT (instr_accept),
        .BRANCH_TAKEN (branch_taken),
        .BRANCH_TARGET(branch_target),
        .FIFO_LEVEL   (fifo_level)
    );

    always #5 clk = ~clk;

    // Program counter: free-runs on negedge, forced to USER_PC whenever USER is high.
    logic [7:0] pc_cnt;
    always @(negedge clk) pc_cnt <= user ? user_pc : pc_cnt + 8'd1;
    assign pc = user ? user_pc : pc_cnt;

    // Reference: next address to fetch, whether the PC is being held, and buffered pairs.
    logic [15:0] mq[$];
    logic [7:0]  m_nf;
    bit          m_hold;
    bit          m_rst;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("USER", {7'd0, user}, {7'd0, m_hold});
        if (m_hold) check("USER_PC", user_pc, m_nf);
        check("PC", pc, m_nf);
        check("MEM_ADDR", mem_addr, m_nf);
        check("MEM_REQ", {7'd0, mem_req}, {7'd0, !m_rst && mq.size() < DEPTH});
        check("INSTR_VALID", {7'd0, instr_valid}, {7'd0, mq.size() != 0});
        check("FIFO_LEVEL", {5'd0, fifo_level}, 8'(mq.size()));
        if (mq.size() != 0) begin
            check("INSTR_PC", instr_pc, mq[0][15:8]);
            check("INSTR", instr, mq[0][7:0]);
        end
    endtask

    task automatic model_update(input bit rdy, input bit acc, input bit br,
                                input logic [7:0] tgt, input logic [7:0] rdata);
        int sz;
        sz = mq.size();
        if (br) begin
            mq.delete();
            m_nf   = tgt;
            m_hold = 1'b1;
        end else begin
            if (acc && sz > 0) void'(mq.pop_front());
            if (sz < DEPTH && rdy) begin
                mq.push_back({m_nf, rdata});
                m_nf   = m_nf + 8'd1;
                m_hold = 1'b0;
            end else begin
                m_hold = 1'b1;
            end
        end
    endtask

    // One clock: drive inputs mid-low-phase, check against the model, then advance the model.
    task automatic cycle(input bit r, input bit rdy, input bit acc, input bit br,
                         input logic [7:0] tgt);
        logic [7:0] rdata;
        @(negedge clk);
        #1;
        rdata         = 8'($urandom);
        rst           = r;
        mem_ready     = rdy;
        instr_accept  = acc;
        branch_taken  = br;
        branch_target = tgt;
        mem_rdata     = rdata;
        if (r) begin
            mq.delete();
            m_nf   = RV;
            m_hold = 1'b1;
        end
        m_rst = r;
        #1;
        check_outputs();
        @(posedge clk);
        if (!r) model_update(rdy, acc, br, tgt, rdata);
    endtask

    initial begin
        mq.delete();
        m_nf   = RV;
        m_hold = 1'b1;
        m_rst  = 1'b1;

        // Reset, then stream 00.. with memory always ready and decode always accepting.
        cycle(1, 1, 1, 0, 8'h00);
        cycle(1, 1, 1, 0, 8'h00);
        repeat (5) cycle(0, 1, 1, 0, 8'h00);

        // Memory stall at 05 for three cycles, then resume.
        repeat (3) cycle(0, 0, 1, 0, 8'h00);
        repeat (2) cycle(0, 1, 1, 0, 8'h00);

        // Fill the buffer from 00 with no accepts, pop one, then 04 is pushed.
        cycle(0, 1, 1, 1, 8'h00);
        repeat (6) cycle(0, 1, 0, 0, 8'h00);
        cycle(0, 1, 1, 0, 8'h00);
        cycle(0, 1, 0, 0, 8'h00);

        // Drop to three entries, branch to 40, then fetch 40, 41.
        cycle(0, 0, 1, 0, 8'h00);
        cycle(0, 1, 1, 1, 8'h40);
        repeat (3) cycle(0, 1, 0, 0, 8'h00);

        // Address wrap FE, FF, 00, 01.
        cycle(0, 1, 1, 1, 8'hFE);
        repeat (6) cycle(0, 1, 1, 0, 8'h00);

        // Hold at 22 with two entries buffered, then reset mid-operation.
        cycle(0, 1, 1, 1, 8'h20);
        repeat (2) cycle(0, 1, 0, 0, 8'h00);
        cycle(0, 0, 0, 0, 8'h00);
        repeat (2) cycle(1, 1, 1, 0, 8'h00);
        repeat (4) cycle(0, 1, 1, 0, 8'h00);

        // Randomized traffic with occasional branches and resets.
        repeat (400) begin
            cycle(($urandom % 64) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                  ($urandom % 12) == 0, 8'($urandom));
        end
        cycle(0, 1, 1, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
